// File: rtl/cache_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_axi_pkg
// Description : Shared AXI3 encodings, bridge FSM state codes and ID helpers
//               for the cache-to-AXI burst bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_axi_pkg;

    // AXI burst type encodings
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] BURST_WRAP = 2'b10;

    // Transfer size: one 32-bit word per beat
    localparam logic [2:0] SIZE_4B    = 3'b010;

    // Bridge FSM state encodings
    localparam int         STATE_W    = 3;
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_AR      = 3'd1;
    localparam logic [2:0] ST_R       = 3'd2;
    localparam logic [2:0] ST_AW      = 3'd3;
    localparam logic [2:0] ST_W       = 3'd4;
    localparam logic [2:0] ST_B       = 3'd5;

    // Padding placed above the instruction/data bit in ID and PROT fields
    localparam logic [2:0] ID_PAD     = 3'b000;
    localparam logic [1:0] PROT_PAD   = 2'b00;

    function automatic logic [3:0] axi_id(input logic id_bit);
        return {ID_PAD, id_bit};
    endfunction

    function automatic logic [2:0] axi_prot(input logic id_bit);
        return {PROT_PAD, id_bit};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_axi_burst_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : cache_axi_burst_bridge_if
// Description : AXI3 bus bundle (32-bit data, 4-bit IDs, 8-bit len) between
//               the burst bridge (master) and memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface cache_axi_burst_bridge_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface
`default_nettype wire

// File: rtl/axi_beat_counter.sv
`default_nettype none
// ============================================================================
// Module      : axi_beat_counter
// Description : 5-bit beat counter with synchronous clear and a flag that is
//               high while the count equals the final beat index.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_beat_counter (
    input  wire logic       clk,
    input  wire logic       rstn,
    input  wire logic       clear,
    input  wire logic       inc,
    input  wire logic [4:0] last_idx,
    output logic [4:0]      count,
    output logic            is_last
);

    logic [4:0] r_count;

    // Count handshaken beats; clear has priority over increment
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_count <= 5'd0;
        end else if (clear) begin
            r_count <= 5'd0;
        end else if (inc) begin
            r_count <= r_count + 5'd1;
        end
    end

    assign count   = r_count;
    assign is_last = (r_count == last_idx);

endmodule
`default_nettype wire

// File: rtl/cache_axi_burst_bridge.sv
`default_nettype none
// ============================================================================
// Module      : cache_axi_burst_bridge
// Description : Turns single cache line fill/evict or uncached single-word
//               requests into one AXI3 read or write burst at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_axi_burst_bridge
    import cache_axi_pkg::*;
#(
    parameter logic ID          = 1'b0,
    parameter int   BURST_WORDS = 8,
    parameter bit   WRAP        = 1'b1
) (
    input  wire logic        clk,
    input  wire logic        rstn,
    input  wire logic        req_valid,
    output logic             req_ready,
    input  wire logic        req_wen,
    input  wire logic        req_single,
    input  wire logic [31:0] req_addr,
    input  wire logic [3:0]  req_wstrb,
    input  wire logic [31:0] wbeat_data,
    output logic             wbeat_ready,
    output logic [31:0]      rbeat_data,
    output logic             rbeat_valid,
    output logic             rbeat_last,
    output logic             done,
    output logic             err,
    cache_axi_burst_bridge_if.master axi
);

    localparam logic [4:0]  c_last_burst = 5'(BURST_WORDS - 1);
    localparam logic [31:0] c_line_mask  = 32'(4 * BURST_WORDS - 1);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;
    logic [31:0]        r_addr;
    logic               r_wen;
    logic               r_single;
    logic [3:0]         r_wstrb;
    logic               r_err_acc;

    logic               w_accept;
    logic [4:0]         w_last_idx;
    logic [31:0]        w_axaddr;
    logic [1:0]         w_burst;
    logic               w_cnt_clear;
    logic               w_cnt_inc;
    logic [4:0]         w_beat_count;
    logic               w_is_last;
    logic               w_unused;

    assign w_accept   = req_valid && (r_state == ST_IDLE);
    assign w_last_idx = r_single ? 5'd0 : c_last_burst;
    assign w_burst    = (r_single || !WRAP) ? BURST_INCR : BURST_WRAP;
    // Wrap and single accesses start at the requested word; INCR starts at the line base
    assign w_axaddr   = r_addr & ~((r_single || WRAP) ? 32'h3 : c_line_mask);

    assign w_cnt_clear = (r_state == ST_IDLE);
    assign w_cnt_inc   = ((r_state == ST_R) && axi.rvalid) || ((r_state == ST_W) && axi.wready);

    axi_beat_counter u_beat_counter (
        .clk      (clk),
        .rstn     (rstn),
        .clear    (w_cnt_clear),
        .inc      (w_cnt_inc),
        .last_idx (w_last_idx),
        .count    (w_beat_count),
        .is_last  (w_is_last)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state: one transaction at a time, back to IDLE after completion
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (req_valid)                   w_next_state = req_wen ? ST_AW : ST_AR;
            ST_AR:   if (axi.arready)                 w_next_state = ST_R;
            ST_R:    if (axi.rvalid && axi.rlast)     w_next_state = ST_IDLE;
            ST_AW:   if (axi.awready)                 w_next_state = ST_W;
            ST_W:    if (axi.wready && w_is_last)     w_next_state = ST_B;
            ST_B:    if (axi.bvalid)                  w_next_state = ST_IDLE;
            default:                                  w_next_state = ST_IDLE;
        endcase
    end

    // Request capture and read-error accumulation across the burst
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_addr    <= 32'd0;
            r_wen     <= 1'b0;
            r_single  <= 1'b0;
            r_wstrb   <= 4'd0;
            r_err_acc <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr   <= req_addr;
                r_wen    <= req_wen;
                r_single <= req_single;
                r_wstrb  <= req_wstrb;
            end
            if (r_state == ST_IDLE) begin
                r_err_acc <= 1'b0;
            end else if ((r_state == ST_R) && axi.rvalid) begin
                r_err_acc <= r_err_acc | axi.rresp[1];
            end
        end
    end

    // FSM outputs; handshake outputs are forced low while reset is asserted
    always_comb begin
        req_ready   = 1'b0;
        axi.arvalid = 1'b0;
        axi.araddr  = 32'd0;
        axi.rready  = 1'b0;
        rbeat_valid = 1'b0;
        rbeat_last  = 1'b0;
        axi.awvalid = 1'b0;
        axi.awaddr  = 32'd0;
        axi.wvalid  = 1'b0;
        axi.wlast   = 1'b0;
        wbeat_ready = 1'b0;
        axi.bready  = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        if (rstn) begin
            case (r_state)
                ST_IDLE: req_ready = 1'b1;
                ST_AR: begin
                    axi.arvalid = 1'b1;
                    axi.araddr  = w_axaddr;
                end
                ST_R: begin
                    axi.rready  = 1'b1;
                    rbeat_valid = axi.rvalid;
                    rbeat_last  = axi.rlast;
                    if (axi.rvalid && axi.rlast) begin
                        done = 1'b1;
                        // A short or long burst is reported as an error too
                        err  = r_err_acc | axi.rresp[1] | !w_is_last;
                    end
                end
                ST_AW: begin
                    axi.awvalid = 1'b1;
                    axi.awaddr  = w_axaddr;
                end
                ST_W: begin
                    axi.wvalid  = 1'b1;
                    axi.wlast   = w_is_last;
                    wbeat_ready = axi.wready;
                end
                ST_B: begin
                    axi.bready = 1'b1;
                    if (axi.bvalid) begin
                        done = 1'b1;
                        err  = axi.bresp[1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign rbeat_data  = axi.rdata;
    assign axi.wdata   = wbeat_data;
    assign axi.wstrb   = r_single ? r_wstrb : 4'hF;

    assign axi.arid    = axi_id(ID);
    assign axi.arlen   = {3'b000, w_last_idx};
    assign axi.arsize  = SIZE_4B;
    assign axi.arburst = w_burst;
    assign axi.arlock  = 2'b00;
    assign axi.arcache = 4'b0000;
    assign axi.arprot  = axi_prot(ID);

    assign axi.awid    = axi_id(ID);
    assign axi.awlen   = {3'b000, w_last_idx};
    assign axi.awsize  = SIZE_4B;
    assign axi.awburst = w_burst;
    assign axi.awlock  = 2'b00;
    assign axi.awcache = 4'b0000;
    assign axi.awprot  = axi_prot(ID);
    assign axi.wid     = axi_id(ID);

    // Response IDs are not needed with a single outstanding transaction
    assign w_unused = &{1'b0, axi.rid, axi.bid, axi.rresp[0], axi.bresp[0], w_beat_count, r_wen};

endmodule
`default_nettype wire

// File: tb/tb_cache_axi_burst_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_axi_burst_bridge
// Description : Directed bench for two bridge instances driven in lockstep:
//               a: ID=0, WRAP=1   b: ID=1, WRAP=0   (both BURST_WORDS=8)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_axi_burst_bridge;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid, req_wen, req_single;
    logic [31:0] req_addr;
    logic [3:0]  req_wstrb;
    logic [31:0] wbeat_data;

    logic        arready, awready, wready, bvalid, rvalid, rlast;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;

    logic        req_ready_a, wbeat_ready_a, rbeat_valid_a, rbeat_last_a, done_a, err_a;
    logic        req_ready_b, wbeat_ready_b, rbeat_valid_b, rbeat_last_b, done_b, err_b;
    logic [31:0] rbeat_data_a, rbeat_data_b;

    int n_assert = 0;
    int n_fail   = 0;

    cache_axi_burst_bridge_if ax_a ();
    cache_axi_burst_bridge_if ax_b ();

    assign ax_a.arready = arready;  assign ax_b.arready = arready;
    assign ax_a.awready = awready;  assign ax_b.awready = awready;
    assign ax_a.wready  = wready;   assign ax_b.wready  = wready;
    assign ax_a.bvalid  = bvalid;   assign ax_b.bvalid  = bvalid;
    assign ax_a.bresp   = bresp;    assign ax_b.bresp   = bresp;
    assign ax_a.bid     = 4'd0;     assign ax_b.bid     = 4'd0;
    assign ax_a.rvalid  = rvalid;   assign ax_b.rvalid  = rvalid;
    assign ax_a.rlast   = rlast;    assign ax_b.rlast   = rlast;
    assign ax_a.rdata   = rdata;    assign ax_b.rdata   = rdata;
    assign ax_a.rresp   = rresp;    assign ax_b.rresp   = rresp;
    assign ax_a.rid     = 4'd0;     assign ax_b.rid     = 4'd0;

    cache_axi_burst_bridge #(.ID(1'b0), .BURST_WORDS(8), .WRAP(1'b1)) dut_a (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready_a),
        .req_wen(req_wen), .req_single(req_single), .req_addr(req_addr), .req_wstrb(req_wstrb),
        .wbeat_data(wbeat_data), .wbeat_ready(wbeat_ready_a), .rbeat_data(rbeat_data_a),
        .rbeat_valid(rbeat_valid_a), .rbeat_last(rbeat_last_a), .done(done_a), .err(err_a),
        .axi(ax_a)
    );

    cache_axi_burst_bridge #(.ID(1'b1), .BURST_WORDS(8), .WRAP(1'b0)) dut_b (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready_b),
        .req_wen(req_wen), .req_single(req_single), .req_addr(req_addr), .req_wstrb(req_wstrb),
        .wbeat_data(wbeat_data), .wbeat_ready(wbeat_ready_b), .rbeat_data(rbeat_data_b),
        .rbeat_valid(rbeat_valid_b), .rbeat_last(rbeat_last_b), .done(done_b), .err(err_b),
        .axi(ax_b)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_a, input logic [31:0] exp_b,
                           input int stall, input int nbeats, input int bad, input logic exp_err);
        cyc();
        req_valid = 1'b1; req_wen = 1'b0; req_single = 1'b0; req_addr = addr; #1;
        check("rd_req_ready", req_ready_a, 1);
        cyc();
        req_valid = 1'b0; arready = (stall == 0); #1;
        check("arvalid_a", ax_a.arvalid, 1);
        check("arvalid_b", ax_b.arvalid, 1);
        check("araddr_a", ax_a.araddr, exp_a);
        check("araddr_b", ax_b.araddr, exp_b);
        check("arlen_a", ax_a.arlen, 7);
        check("arsize_a", ax_a.arsize, 3'b010);
        check("arburst_a", ax_a.arburst, 2'b10);
        check("arburst_b", ax_b.arburst, 2'b01);
        check("arid_a", ax_a.arid, 4'd0);
        check("arid_b", ax_b.arid, 4'd1);
        check("arprot_b", ax_b.arprot, 3'd1);
        for (int i = 0; i < stall; i++) begin
            cyc();
            arready = (i == stall - 1); #1;
            check("ar_stall_addr", ax_a.araddr, exp_a);
            check("ar_stall_len", ax_a.arlen, 7);
            check("ar_stall_valid", ax_a.arvalid, 1);
            check("ar_stall_req_ready", req_ready_a, 0);
        end
        cyc();
        arready = 1'b0;
        for (int b = 1; b <= nbeats; b++) begin
            if (b == 3) begin
                rvalid = 1'b0; rlast = 1'b0; #1;
                check("r_gap_valid", rbeat_valid_a, 0);
                check("r_gap_rready", ax_a.rready, 1);
                check("r_gap_done", done_a, 0);
                cyc();
            end
            rvalid = 1'b1; rdata = 32'hA5A5_0000 | 32'(b); rlast = (b == nbeats);
            rresp = (b == bad) ? 2'b10 : 2'b00; #1;
            check("rbeat_valid", rbeat_valid_a, 1);
            check("rbeat_data", rbeat_data_a, 32'hA5A5_0000 | 32'(b));
            check("rbeat_last", rbeat_last_a, (b == nbeats));
            check("r_done_a", done_a, (b == nbeats));
            check("r_done_b", done_b, (b == nbeats));
            check("r_req_ready", req_ready_a, 0);
            if (b == nbeats) begin
                check("r_err_a", err_a, exp_err);
                check("r_err_b", err_b, exp_err);
            end
            cyc();
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; #1;
        check("r_post_done", done_a, 0);
        check("r_post_req_ready", req_ready_a, 1);
        check("r_post_araddr", ax_a.araddr, 0);
        check("r_post_arvalid", ax_a.arvalid, 0);
        check("r_post_rready", ax_a.rready, 0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic single, input logic [3:0] strb,
                            input logic [31:0] exp_a, input logic [31:0] exp_b,
                            input logic [1:0] burst_a, input logic [1:0] burst_b,
                            input logic [7:0] len, input bit toggle, input logic [1:0] resp);
        int nb;
        int beat;
        nb   = int'(len) + 1;
        beat = 0;
        cyc();
        req_valid = 1'b1; req_wen = 1'b1; req_single = single; req_addr = addr; req_wstrb = strb; #1;
        check("wr_req_ready", req_ready_a, 1);
        cyc();
        req_valid = 1'b0; awready = 1'b0; #1;
        check("awvalid_a", ax_a.awvalid, 1);
        check("awaddr_a", ax_a.awaddr, exp_a);
        check("awaddr_b", ax_b.awaddr, exp_b);
        check("awburst_a", ax_a.awburst, burst_a);
        check("awburst_b", ax_b.awburst, burst_b);
        check("awlen_a", ax_a.awlen, len);
        check("awsize_a", ax_a.awsize, 3'b010);
        check("awid_b", ax_b.awid, 4'd1);
        check("aw_wvalid", ax_a.wvalid, 0);
        check("aw_araddr", ax_a.araddr, 0);
        cyc();
        awready = 1'b1; #1;
        check("aw_hs_wvalid", ax_a.wvalid, 0);
        cyc();
        awready = 1'b0;
        for (int c = 0; c < 64 && beat < nb; c++) begin
            wready = toggle ? (c % 2 == 1) : 1'b1;
            wbeat_data = 32'hD00D_0000 | 32'(beat); #1;
            check("wvalid", ax_a.wvalid, 1);
            check("wdata", ax_a.wdata, 32'hD00D_0000 | 32'(beat));
            check("wstrb", ax_a.wstrb, single ? strb : 4'hF);
            check("wlast_a", ax_a.wlast, (beat == nb - 1));
            check("wlast_b", ax_b.wlast, (beat == nb - 1));
            check("wbeat_ready", wbeat_ready_a, wready);
            check("w_done", done_a, 0);
            if (wready) beat++;
            cyc();
        end
        check("w_beats", beat, nb);
        wready = 1'b0; bvalid = 1'b0; #1;
        check("b_bready", ax_a.bready, 1);
        check("b_wvalid", ax_a.wvalid, 0);
        check("b_wait_done", done_a, 0);
        cyc();
        bvalid = 1'b1; bresp = resp; #1;
        check("b_done_a", done_a, 1);
        check("b_done_b", done_b, 1);
        check("b_err_a", err_a, resp[1]);
        check("b_err_b", err_b, resp[1]);
        cyc();
        bvalid = 1'b0; bresp = 2'b00; #1;
        check("b_post_done", done_a, 0);
        check("b_post_req_ready", req_ready_a, 1);
        check("b_post_awaddr", ax_a.awaddr, 0);
        check("b_post_bready", ax_a.bready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_single = 1'b0;
        req_addr = 32'd0; req_wstrb = 4'd0; wbeat_data = 32'd0;
        arready = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        rvalid = 1'b0; rlast = 1'b0; rdata = 32'd0; rresp = 2'b00; bresp = 2'b00;

        // Reset: everything quiet while held and right after release
        repeat (3) cyc();
        check("rst_req_ready", req_ready_a, 0);
        check("rst_arvalid", ax_a.arvalid, 0);
        check("rst_done", done_a, 0);
        rstn = 1'b1; #1;
        check("idle_req_ready_a", req_ready_a, 1);
        check("idle_req_ready_b", req_ready_b, 1);
        check("idle_arvalid", ax_a.arvalid, 0);
        check("idle_awvalid", ax_a.awvalid, 0);
        check("idle_araddr", ax_a.araddr, 0);
        check("idle_awaddr", ax_b.awaddr, 0);
        check("idle_wvalid", ax_a.wvalid, 0);
        check("idle_rready", ax_a.rready, 0);
        check("idle_bready", ax_a.bready, 0);

        // Line read with a 10-cycle arready stall
        do_read(32'h1000_0014, 32'h1000_0014, 32'h1000_0000, 10, 8, 0, 1'b0);

        // Line write, wready toggling
        do_write(32'h2000_0018, 1'b0, 4'h0, 32'h2000_0018, 32'h2000_0000,
                 2'b10, 2'b01, 8'd7, 1'b1, 2'b00);

        // Single uncached write with partial strobe and slave error
        do_write(32'h3000_0006, 1'b1, 4'b0011, 32'h3000_0004, 32'h3000_0004,
                 2'b01, 2'b01, 8'd0, 1'b0, 2'b10);

        // Read with SLVERR on beat 3
        do_read(32'h1000_003C, 32'h1000_003C, 32'h1000_0020, 0, 8, 3, 1'b1);

        // Read cut short by rlast on beat 5
        do_read(32'h1000_0044, 32'h1000_0044, 32'h1000_0040, 0, 5, 0, 1'b1);

        // Reset in the middle of a write data phase
        cyc();
        req_valid = 1'b1; req_wen = 1'b1; req_single = 1'b0; req_addr = 32'h5000_0000; #1;
        cyc();
        req_valid = 1'b0; awready = 1'b1; #1;
        check("mr_awvalid", ax_a.awvalid, 1);
        cyc();
        awready = 1'b0; wready = 1'b1; wbeat_data = 32'h1234_5678; #1;
        check("mr_wvalid_1", ax_a.wvalid, 1);
        cyc();
        check("mr_wvalid_2", ax_a.wvalid, 1);
        cyc();
        rstn = 1'b0; #1;
        check("mr_rst_wvalid_a", ax_a.wvalid, 0);
        check("mr_rst_wvalid_b", ax_b.wvalid, 0);
        check("mr_rst_done", done_a, 0);
        check("mr_rst_req_ready", req_ready_a, 0);
        cyc();
        rstn = 1'b1; wready = 1'b0; #1;
        check("mr_post_wvalid", ax_a.wvalid, 0);
        check("mr_post_awvalid", ax_a.awvalid, 0);
        check("mr_post_bready", ax_a.bready, 0);
        check("mr_post_done", done_a, 0);
        check("mr_post_req_ready", req_ready_a, 1);

        // Normal read after the abandoned write
        do_read(32'h4000_0008, 32'h4000_0008, 32'h4000_0000, 0, 8, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_axi_burst_bridge.md
CACHE_AXI_BURST_BRIDGE -- requirements
Module: cache_axi_burst_bridge

Interface
REQ-001 Parameter ID, default 1'b0, AXI ID bit (1 = instruction, 0 = data); arid/awid/wid = {3'b000,ID}, arprot/awprot = {2'b00,ID}.
REQ-002 Parameter BURST_WORDS, default 8, beats per line burst; legal values 1, 2, 4, 8, 16.
REQ-003 Parameter WRAP, default 1; 1 = WRAP burst with critical word first, 0 = INCR burst from the line-aligned address.
REQ-004 clk  in  1  the single clock; all logic is on the posedge.
REQ-005 rstn  in  1  reset, synchronous, active-low.
REQ-006 req_valid/req_ready  in/out  1/1  cache request handshake.
REQ-007 req_wen, req_single  in  1, 1  write=1; single-beat uncached access=1.
REQ-008 req_addr, req_wstrb  in  32, 4  byte address; byte strobe, used only when req_single=1.
REQ-009 wbeat_data in 32, wbeat_ready out 1  write beat source; a beat is consumed when wbeat_ready=1.
REQ-010 rbeat_data out 32, rbeat_valid out 1, rbeat_last out 1  returned read beats.
REQ-011 done out 1, err out 1  one-cycle completion pulse; err is valid only with done.
REQ-012 AXI3 master ports ar*, r*, aw*, w*, b*  32-bit data, 4-bit IDs, 8-bit len.

Function
REQ-013 The FSM SHALL have states IDLE, AR, R, AW, W, B; req_ready=1 only in IDLE.
REQ-014 On req_valid&req_ready the block SHALL latch addr/wen/single/wstrb and enter AR (wen=0) or AW (wen=1) the next cycle.
REQ-015 Beat count: L = 1 if single, else BURST_WORDS; arlen = awlen = L-1; arsize = awsize = 3'b010.
REQ-016 Burst type: arburst/awburst = 2'b01 if single or WRAP=0, else 2'b10.
REQ-017 Address: axaddr = {addr[31:2],2'b00} if single or WRAP=1, else addr with the low log2(4*BURST_WORDS) bits cleared.
REQ-018 arvalid/awvalid SHALL be high throughout AR/AW with stable payload until ready; the handshake cycle moves to R/W.
REQ-019 R: rready=1; rbeat_valid = rvalid, rbeat_data = rdata, rbeat_last = rlast, combinationally in the same cycle.
REQ-020 R exit: on rvalid&rlast go to IDLE and pulse done; err = OR of rresp[1] over all beats, OR a beat-count mismatch at rlast.
REQ-021 W: wvalid=1, wdata = wbeat_data, wbeat_ready = wready; a 5-bit beat counter increments per wready, and wlast = (count == L-1).
REQ-022 W strobe: wstrb = latched req_wstrb if single, else 4'hF; after the last beat handshakes go to B.
REQ-023 B: bready=1; on bvalid go to IDLE and pulse done with err = bresp[1].
REQ-024 Write data SHALL NOT be issued before the AW handshake completes; only one transaction is outstanding at a time.
REQ-025 A req_valid while not IDLE SHALL be stalled (req_ready=0), not dropped; back-to-back requests accept at the earliest in the cycle after done.
REQ-026 rid and bid SHALL be ignored; arlock = awlock = 0 and arcache = awcache = 0.
REQ-027 When idle, araddr and awaddr SHALL be 0 and all AXI valid/ready outputs SHALL be 0.

Reset
REQ-028 While rstn=0 at posedge: state=IDLE, beat counter=0, err accumulator=0, latched fields=0.
REQ-029 All valid/ready/done outputs SHALL be 0 during and immediately after reset; a reset mid-transaction abandons the burst with no done pulse.

Structure
REQ-030 Package cache_axi_pkg SHALL hold the burst encodings (INCR, WRAP), the SIZE_4B constant, the state encodings and the ID-composition helper constants.
REQ-031 The beat counter (clear, inc, count, is_last against L-1) SHALL be sub-module axi_beat_counter; everything else stays in one module.

Verification
REQ-032 Read, BURST_WORDS=8, WRAP=1, addr 0x1000_0014 -> araddr 0x1000_0014, arlen 7, arburst 2'b10; 8 rbeat_valid, last beat flagged; done=1, err=0.
REQ-033 Write, WRAP=0, addr 0x2000_0018 -> awaddr 0x2000_0000, awburst 2'b01; 8 beats with wstrb F, wlast on beat 8, wready toggling every cycle; done after bvalid.
REQ-034 Single write, req_wstrb 4'b0011 -> awlen 0, wlast on the first beat, wstrb 4'b0011.
REQ-035 Read with rresp=2'b10 on beat 3 -> err=1 with done; a read terminated by early rlast at beat 5 -> err=1.
REQ-036 arready held low for 10 cycles -> araddr/arlen stable, req_ready=0; rstn low during W -> all valids 0 next cycle, no done pulse.
